regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-side controller for the MIPS register file. It merges two result sources onto the single register-file write port. The in-order pipeline writeback has priority. Long-latency results (load-miss / mul-div) arrive through a ready/valid handshake and are buffered in a small FIFO. A per-register scoreboard marks outstanding long-latency destinations and drives decode-stage stall flags for the read ports.

Parameters:
DATA_WIDTH, 32, register data width
REG_DEPTH, 32, number of architectural registers
ADDR_WIDTH, 5, register address width (log2 of REG_DEPTH)
RD_DEPTH, 2, number of decode read ports checked for hazards
FIFO_DEPTH, 4, long-latency result buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wb_valid  in  1  pipeline writeback valid
wb_jal  in  1  pipeline writeback is jump-and-link (destination r31)
wb_rd  in  ADDR_WIDTH  pipeline destination register
wb_data  in  DATA_WIDTH  pipeline result
ll_valid  in  1  long-latency result valid
ll_ready  out  1  long-latency result accepted this cycle when ll_valid=1
ll_rd  in  ADDR_WIDTH  long-latency destination register
ll_data  in  DATA_WIDTH  long-latency result
iss_valid  in  1  long-latency op issued this cycle
iss_rd  in  ADDR_WIDTH  destination of issued op
hz_rr  in  ADDR_WIDTH*RD_DEPTH  packed decode read addresses; port i at [ADDR_WIDTH*i +: ADDR_WIDTH]
hz_stall  out  RD_DEPTH  bit i = read port i must stall
rf_wr  out  1  register-file write enable (registered)
rf_jal  out  1  register-file jal write (registered)
rf_rw  out  ADDR_WIDTH  register-file write address (registered)
rf_d  out  DATA_WIDTH  register-file write data (registered)
fifo_count  out  log2(FIFO_DEPTH)+1  buffered entries

Behaviour:
- Reset: rf_wr=0, rf_jal=0, rf_rw=0, rf_d=0, fifo_count=0, all pending bits cleared, hz_stall=0. ll_ready=0 while rst=1. Reset mid-operation discards every buffered result and every pending bit.
- ll_ready = !rst && (fifo_count < FIFO_DEPTH). It does not depend on ll_valid.
- Push: ll_valid && ll_ready pushes {ll_rd, ll_data} at the clock edge. If ll_rd=0 the result is accepted but dropped; no push occurs.
- Arbitration at each edge, one write emitted per cycle, latency 1 (output registers update at the edge after the inputs are sampled):
  - If wb_valid: emit the pipeline write. rf_jal=wb_jal; rf_rw=31 if wb_jal, else wb_rd; rf_d=wb_data. The FIFO does not pop.
  - Else if the FIFO is non-empty: pop the head and emit it with rf_jal=0.
  - Else: rf_wr=0; rf_rw, rf_d and rf_jal hold their previous values.
  - rf_wr=1 only when the effective destination is non-zero (jal is always non-zero). A pipeline write to r0 still wins arbitration and blocks the pop that cycle.
- Push and pop in the same cycle are allowed when not full; fifo_count is unchanged. When full, no push is possible, even if a pop occurs the same cycle.
- FIFO order is strict first-in first-out. Read/write pointers wrap modulo FIFO_DEPTH.
- Scoreboard: pending[REG_DEPTH].
  - iss_valid && iss_rd!=0 sets pending[iss_rd].
  - A FIFO pop clears pending[popped rd] at the same edge the pop's rf_wr is registered.
  - Set and clear of the same register in the same cycle: set wins.
  - Issuing to a register already pending is a protocol violation; behaviour is unspecified and it is not tested.
  - Pipeline writes never touch pending.
- hz_stall[i] is combinational. It is 1 iff rr_i != 0 and either pending[rr_i]=1, or rf_wr=1 and rf_rw=rr_i (covers the cycle before the register file commits the write).
- Long-latency results whose rd was never issued are written normally; the clear has no effect.

Test Plan:
1. Reset, then idle 3 cycles -> rf_wr=0, ll_ready=1, fifo_count=0, hz_stall=2'b00.
2. wb_valid=1, wb_rd=5, wb_data=32'hDEADBEEF for one cycle -> next cycle rf_wr=1, rf_rw=5, rf_d=32'hDEADBEEF, rf_jal=0. Then wb_jal=1, wb_rd=0, wb_data=32'h00400008 -> rf_wr=1, rf_jal=1, rf_rw=31.
3. Issue iss_rd=9, hold hz_rr={5'd0,5'd9} -> hz_stall[0]=1. ll push rd=9, data=32'h12345678 with wb idle -> rf_wr=1, rf_rw=9 one cycle after the push. hz_stall[0] stays 1 through the rf_wr cycle and drops to 0 the cycle after.
4. Hold wb_valid=1 continuously while pushing 5 ll results (rd=1..5) -> after 4 pushes fifo_count=4, ll_ready=0, 5th not accepted. Drop wb_valid -> writes rd=1,2,3,4 on consecutive cycles in order. ll_ready returns to 1 the cycle after the first pop.
5. Concurrent push and pop: FIFO holds 2 entries, wb idle, push rd=7 -> fifo_count stays 2 and rd=7 drains last. Push with ll_rd=0 -> fifo_count unchanged, no rf_wr for it.
6. Reset asserted with 3 buffered entries and pending[3,4] set -> all pending cleared, fifo_count=0, rf_wr=0, and no stale writes appear after reset is released.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback has priority over buffered
// long-latency results. A scoreboard of pending destinations drives the decode stall flags.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_DEPTH  = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_DEPTH   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid,
    input  logic                         wb_jal,
    input  logic [ADDR_WIDTH-1:0]        wb_rd,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         ll_valid,
    output logic                         ll_ready,
    input  logic [ADDR_WIDTH-1:0]        ll_rd,
    input  logic [DATA_WIDTH-1:0]        ll_data,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_rd,
    input  logic [ADDR_WIDTH*RD_DEPTH-1:0] hz_rr,
    output logic [RD_DEPTH-1:0]          hz_stall,
    output logic                         rf_wr,
    output logic                         rf_jal,
    output logic [ADDR_WIDTH-1:0]        rf_rw,
    output logic [DATA_WIDTH-1:0]        rf_d,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [REG_DEPTH-1:0]  pend_q, pend_d;
    logic                  rf_wr_q, rf_jal_q;
    logic [ADDR_WIDTH-1:0] rf_rw_q;
    logic [DATA_WIDTH-1:0] rf_d_q;

    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] wb_dst, head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    assign ll_ready  = !rst && (count_q != CW'(FIFO_DEPTH));
    // Results for r0 are handshaken but never stored.
    assign push      = ll_valid && ll_ready && (ll_rd != '0);
    assign pop       = !wb_valid && (count_q != '0);
    assign head_rd   = fifo_rd_q[rptr_q];
    assign head_data = fifo_data_q[rptr_q];
    assign wb_dst    = wb_jal ? ADDR_WIDTH'(31) : wb_rd;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    // Clear first so a same-cycle issue to the popped register stays pending.
    always_comb begin
        pend_d = pend_q;
        if (pop)
            pend_d[head_rd] = 1'b0;
        if (iss_valid && (iss_rd != '0))
            pend_d[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= ll_rd;
            fifo_data_q[wptr_q] <= ll_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            rf_wr_q  <= 1'b0;
            rf_jal_q <= 1'b0;
            rf_rw_q  <= '0;
            rf_d_q   <= '0;
        end else begin
            count_q <= count_d;
            pend_q  <= pend_d;
            if (push)
                wptr_q <= wptr_q + PW'(1);
            if (pop)
                rptr_q <= rptr_q + PW'(1);
            if (wb_valid) begin
                rf_wr_q  <= (wb_dst != '0);
                rf_jal_q <= wb_jal;
                rf_rw_q  <= wb_dst;
                rf_d_q   <= wb_data;
            end else if (pop) begin
                rf_wr_q  <= (head_rd != '0);
                rf_jal_q <= 1'b0;
                rf_rw_q  <= head_rd;
                rf_d_q   <= head_data;
            end else begin
                rf_wr_q  <= 1'b0;
            end
        end
    end

    // A write sitting in the output register is not yet visible in the file.
    for (genvar i = 0; i < RD_DEPTH; i++) begin : g_hz
        logic [ADDR_WIDTH-1:0] rr;
        assign rr          = hz_rr[ADDR_WIDTH*i +: ADDR_WIDTH];
        assign hz_stall[i] = (rr != '0) && (pend_q[rr] || (rf_wr_q && (rf_rw_q == rr)));
    end

    assign rf_wr      = rf_wr_q;
    assign rf_jal     = rf_jal_q;
    assign rf_rw      = rf_rw_q;
    assign rf_d       = rf_d_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: queue/array reference model checked every cycle, plus literal expectations.
module tb_regfile_wb_arbiter;
    localparam int DW = 32, AW = 5, RD = 2, FD = 4;

    logic clk = 1'b0;
    logic rst, wb_valid, wb_jal, ll_valid, iss_valid;
    logic [AW-1:0] wb_rd, ll_rd, iss_rd;
    logic [DW-1:0] wb_data, ll_data;
    logic [AW*RD-1:0] hz_rr;
    logic ll_ready, rf_wr, rf_jal;
    logic [RD-1:0] hz_stall;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_d;
    logic [2:0] fifo_count;

    int n_chk = 0, n_fail = 0;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .REG_DEPTH(32), .ADDR_WIDTH(AW),
                         .RD_DEPTH(RD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_jal(wb_jal), .wb_rd(wb_rd),
        .wb_data(wb_data), .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd),
        .ll_data(ll_data), .iss_valid(iss_valid), .iss_rd(iss_rd), .hz_rr(hz_rr),
        .hz_stall(hz_stall), .rf_wr(rf_wr), .rf_jal(rf_jal), .rf_rw(rf_rw), .rf_d(rf_d),
        .fifo_count(fifo_count));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of buffered results and a flat pending array.
    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] d; } ent_t;
    ent_t q[$];
    logic [31:0] pend;
    logic m_wr, m_jal;
    logic [AW-1:0] m_rw;
    logic [DW-1:0] m_d;

    always @(posedge clk) begin : model
        ent_t e;
        logic acc;
        if (rst) begin
            q.delete();
            pend = '0;
            m_wr = 0; m_jal = 0; m_rw = '0; m_d = '0;
        end else begin
            acc = ll_valid && (q.size() < FD);
            if (wb_valid) begin
                m_jal = wb_jal;
                m_rw  = wb_jal ? 5'd31 : wb_rd;
                m_d   = wb_data;
                m_wr  = (m_rw != 0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_rw = e.rd; m_d = e.d; m_jal = 0; m_wr = 1;
                pend[e.rd] = 0;
            end else begin
                m_wr = 0;
            end
            if (acc && ll_rd != 0) begin
                e.rd = ll_rd; e.d = ll_data;
                q.push_back(e);
            end
            if (iss_valid && iss_rd != 0) pend[iss_rd] = 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [RD-1:0] st;
        logic [AW-1:0] rr;
        for (int i = 0; i < RD; i++) begin
            rr = hz_rr[AW*i +: AW];
            st[i] = (rr != 0) && (pend[rr] || (m_wr && m_rw == rr));
        end
        chk("m_rf_wr", rf_wr, m_wr);
        chk("m_rf_jal", rf_jal, m_jal);
        chk("m_rf_rw", rf_rw, m_rw);
        chk("m_rf_d", rf_d, m_d);
        chk("m_fifo_count", fifo_count, q.size());
        chk("m_ll_ready", ll_ready, !rst && (q.size() < FD));
        chk("m_hz_stall", hz_stall, st);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; wb_valid = 0; wb_jal = 0; wb_rd = 0; wb_data = 0;
        ll_valid = 0; ll_rd = 0; ll_data = 0; iss_valid = 0; iss_rd = 0; hz_rr = 0;
        step(); step();
        chk("rst_ll_ready", ll_ready, 0);
        chk("rst_rf_d", rf_d, 0);
        rst = 0;
        step(); step(); step();
        chk("idle_rf_wr", rf_wr, 0);
        chk("idle_ll_ready", ll_ready, 1);
        chk("idle_count", fifo_count, 0);
        chk("idle_stall", hz_stall, 2'b00);

        // pipeline writes
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        step();
        chk("wb_wr", rf_wr, 1); chk("wb_rw", rf_rw, 5);
        chk("wb_d", rf_d, 32'hDEADBEEF); chk("wb_jal0", rf_jal, 0);
        wb_jal = 1; wb_rd = 0; wb_data = 32'h00400008;
        step();
        chk("jal_wr", rf_wr, 1); chk("jal_jal", rf_jal, 1); chk("jal_rw", rf_rw, 31);
        wb_valid = 0; wb_jal = 0;

        // scoreboard hazard through a long-latency result
        iss_valid = 1; iss_rd = 9; hz_rr = {5'd0, 5'd9};
        step();
        iss_valid = 0;
        chk("iss_stall", hz_stall, 2'b01);
        ll_valid = 1; ll_rd = 9; ll_data = 32'h12345678;
        step();
        ll_valid = 0;
        chk("push_count", fifo_count, 1);
        chk("push_stall", hz_stall, 2'b01);
        step();
        chk("ll_wr", rf_wr, 1); chk("ll_rw", rf_rw, 9); chk("ll_d", rf_d, 32'h12345678);
        chk("ll_stall_wr", hz_stall, 2'b01);
        step();
        chk("ll_stall_clr", hz_stall, 2'b00);
        hz_rr = 0;

        // fill while pipeline holds the port
        wb_valid = 1; wb_rd = 2; wb_data = 32'h22;
        for (int i = 1; i <= 5; i++) begin
            ll_valid = 1; ll_rd = AW'(i); ll_data = 32'hA0 + i;
            step();
            if (i == 4) begin
                chk("full_count", fifo_count, 4);
                chk("full_ready", ll_ready, 0);
            end
        end
        chk("full_reject", fifo_count, 4);
        ll_valid = 0; wb_valid = 0;
        step();
        chk("drain1_rw", rf_rw, 1); chk("drain1_d", rf_d, 32'hA1);
        chk("drain1_ready", ll_ready, 1);
        step(); chk("drain2_rw", rf_rw, 2);
        step(); chk("drain3_rw", rf_rw, 3);
        step(); chk("drain4_rw", rf_rw, 4); chk("drain4_cnt", fifo_count, 0);
        step(); chk("drain_idle", rf_wr, 0);

        // concurrent push/pop
        wb_valid = 1; wb_rd = 0; ll_valid = 1;
        ll_rd = 10; ll_data = 32'h10; step();
        ll_rd = 11; ll_data = 32'h11; step();
        chk("pp_pre", fifo_count, 2);
        wb_valid = 0; ll_rd = 7; ll_data = 32'h77;
        step();
        ll_valid = 0;
        chk("pp_count", fifo_count, 2); chk("pp_rw", rf_rw, 10);
        step(); chk("pp_rw11", rf_rw, 11);
        step(); chk("pp_rw7", rf_rw, 7); chk("pp_d7", rf_d, 32'h77);
        step(); chk("pp_idle", rf_wr, 0);
        wb_valid = 1; wb_rd = 0; ll_valid = 1; ll_rd = 0; ll_data = 32'hBAD;
        step();
        chk("r0_count", fifo_count, 0); chk("r0_wr", rf_wr, 0);
        wb_valid = 0; ll_valid = 0;
        step();
        chk("r0_nowr", rf_wr, 0);

        // reset mid-operation
        iss_valid = 1; iss_rd = 3; step();
        iss_rd = 4; step();
        iss_valid = 0;
        wb_valid = 1; wb_rd = 0; ll_valid = 1;
        ll_rd = 3; step();
        ll_rd = 4; step();
        ll_rd = 6; step();
        ll_valid = 0;
        hz_rr = {5'd4, 5'd3};
        #1;
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_stall", hz_stall, 2'b11);
        rst = 1; wb_valid = 0;
        step();
        chk("mid_rst_count", fifo_count, 0); chk("mid_rst_wr", rf_wr, 0);
        chk("mid_rst_stall", hz_stall, 2'b00); chk("mid_rst_ready", ll_ready, 0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_wr", rf_wr, 0);
            chk("post_rst_count", fifo_count, 0);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
